// File: rtl/uart_ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ram_loader_pkg
// Purpose  : Shared state encodings, the frame start byte and the baud
//            divisor helper for the UART RAM boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_CNT  = 3'd2,
    DATA     = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // UART receiver bit-level states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] c_sync_byte = 8'hA5;

  // Clock cycles per UART bit, rounded to nearest
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_ram_loader_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : 8N1 UART byte receiver. Synchronises rx, qualifies the start
//            bit at mid-bit, samples 8 data bits LSB first and checks the
//            stop bit. Emits a one-cycle valid or frame_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import ram_loader_pkg::*;
#(
  parameter int CLK_HZ = 32000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int c_div = div_calc(CLK_HZ, BAUD);
  localparam int c_cw  = $clog2(c_div + 1);
  localparam logic [c_cw-1:0] c_full = c_cw'(c_div - 1);
  localparam logic [c_cw-1:0] c_half = c_cw'(c_div / 2 - 1);

  logic            r_rx_s1, r_rx_s2, r_rx_d;
  logic            w_fall;
  rx_state_t       r_state, w_state_nxt;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_ferr, w_ferr_nxt;

  // Two-flop synchroniser plus one delay stage for edge detection; idle high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s2;

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Bit timing: start qualified at half a bit, then one sample per bit period
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == c_half) begin
          w_cnt_nxt = '0;
          if (!r_rx_s2) begin
            w_state_nxt = RX_DATA;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = RX_IDLE;   // glitch, not a real start bit
          end
        end
      end
      RX_DATA: begin
        if (r_cnt == c_full) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s2, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
          else               w_bit_nxt   = r_bit + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_full) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_rx_s2) w_valid_nxt = 1'b1;
          else         w_ferr_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign data      = r_shift;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_ram_loader
// Purpose  : Serial boot loader. Parses SYNC / ADDR / COUNT / DATA frames
//            from a UART and writes 32-bit words into darkram's X port,
//            holding the core in reset while a frame is in progress.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ram_loader
  import ram_loader_pkg::*;
#(
  parameter int         CLK_HZ     = 32000000,
  parameter int         BAUD       = 115200,
  parameter int         ADDR_WIDTH = 32,
  parameter int         TIMEOUT    = 1048576,
  parameter logic [7:0] SYNC       = c_sync_byte
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  xdreq,
  output logic                  xrd,
  output logic                  xwr,
  output logic [3:0]            xbe,
  output logic [ADDR_WIDTH-1:0] xaddr,
  output logic [31:0]           xatai,
  input  logic                  xdack,
  output logic                  busy,
  output logic                  cpu_res,
  output logic                  done,
  output logic                  err
);

  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);

  logic [7:0]            w_rx_data;
  logic                  w_rx_valid, w_rx_ferr;
  logic                  w_byte_vld;
  logic [7:0]            w_byte;
  logic [31:0]           w_word;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_idx, w_idx_nxt;
  logic [23:0]           r_asm, w_asm_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_count, w_count_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic                  r_hold_vld, w_hold_vld_nxt;
  logic [7:0]            r_hold, w_hold_nxt;
  logic                  r_abort, w_abort_nxt;
  logic                  r_err, w_err_nxt;
  logic [c_tw-1:0]       r_tmo, w_tmo_nxt;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (w_rx_data),
    .valid     (w_rx_valid),
    .frame_err (w_rx_ferr)
  );

  // A held byte (arrived during a bus cycle) takes priority over a fresh one
  assign w_byte_vld = r_hold_vld | w_rx_valid;
  assign w_byte     = r_hold_vld ? r_hold : w_rx_data;
  // Little-endian: the fourth byte lands in the top lane
  assign w_word     = {w_byte, r_asm};

  // Loader state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_asm      <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_wdata    <= '0;
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
      r_abort    <= 1'b0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_asm      <= w_asm_nxt;
      r_addr     <= w_addr_nxt;
      r_count    <= w_count_nxt;
      r_wdata    <= w_wdata_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_hold     <= w_hold_nxt;
      r_abort    <= w_abort_nxt;
      r_err      <= w_err_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  // Frame parser: header/data assembly, bus cycle sequencing, error aborts
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_asm_nxt      = r_asm;
    w_addr_nxt     = r_addr;
    w_count_nxt    = r_count;
    w_wdata_nxt    = r_wdata;
    w_hold_vld_nxt = r_hold_vld;
    w_hold_nxt     = r_hold;
    w_abort_nxt    = r_abort;
    w_err_nxt      = r_err;
    w_tmo_nxt      = '0;
    case (r_state)
      IDLE: begin
        w_hold_vld_nxt = 1'b0;
        w_abort_nxt    = 1'b0;
        if (w_rx_ferr) begin
          w_err_nxt = 1'b1;
        end else if (w_byte_vld && (w_byte == SYNC)) begin
          w_err_nxt   = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = HDR_ADDR;
        end
      end
      HDR_ADDR, HDR_CNT, DATA: begin
        // Holding register drains here; a fresh byte in the same cycle refills it
        if (r_hold_vld) begin
          if (w_rx_valid) w_hold_nxt     = w_rx_data;
          else            w_hold_vld_nxt = 1'b0;
        end
        if (w_rx_ferr) begin
          w_err_nxt      = 1'b1;
          w_hold_vld_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end else if (w_byte_vld) begin
          w_asm_nxt = {w_byte, r_asm[23:8]};
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == 2'd3) begin
            case (r_state)
              HDR_ADDR: begin
                w_addr_nxt      = ADDR_WIDTH'(w_word);
                w_addr_nxt[1:0] = 2'b00;
                w_state_nxt     = HDR_CNT;
              end
              HDR_CNT: begin
                w_count_nxt = w_word;
                w_state_nxt = (w_word == 32'd0) ? DONE : DATA;
              end
              default: begin
                w_wdata_nxt = w_word;
                w_state_nxt = WRITE;
              end
            endcase
          end
        end else if (r_tmo == c_tmo_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      WRITE: begin
        // Errors during a bus cycle are deferred until xdack so xdreq never drops early
        if (w_rx_valid) begin
          if (r_hold_vld) begin
            w_abort_nxt = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_hold_vld_nxt = 1'b1;
            w_hold_nxt     = w_rx_data;
          end
        end
        if (w_rx_ferr) begin
          w_abort_nxt = 1'b1;
          w_err_nxt   = 1'b1;
        end
        if (xdack) begin
          w_addr_nxt  = r_addr + ADDR_WIDTH'(4);
          w_count_nxt = r_count - 32'd1;
          if (w_abort_nxt) begin
            w_abort_nxt    = 1'b0;
            w_hold_vld_nxt = 1'b0;
            w_state_nxt    = IDLE;
          end else if (r_count == 32'd1) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DONE: begin
        w_hold_vld_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state flop so reset clears them at once
  assign xdreq   = (r_state == WRITE);
  assign xwr     = xdreq;
  assign xrd     = 1'b0;
  assign xbe     = {4{xdreq}};
  assign xaddr   = r_addr;
  assign xatai   = r_wdata;
  assign busy    = (r_state != IDLE);
  assign cpu_res = busy;
  assign done    = (r_state == DONE);
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ram_loader
// Purpose  : Directed self-checking bench for uart_ram_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ram_loader;

  localparam int DIV = 16;   // 160 Hz clock / 10 baud

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        xdack;
  logic        xdreq, xrd, xwr, busy, cpu_res, done, err;
  logic [3:0]  xbe;
  logic [31:0] xaddr, xatai;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          bus_bad, done_cnt, done_long;
  int          dly_min, dly_max;
  bit          no_ack;
  bit          in_req, acked, ack_now, done_prev;
  int          wait_n;
  logic [31:0] cap_a, cap_d;

  uart_ram_loader #(
    .CLK_HZ     (160),
    .BAUD       (10),
    .ADDR_WIDTH (32),
    .TIMEOUT    (400),
    .SYNC       (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .xdreq   (xdreq),
    .xrd     (xrd),
    .xwr     (xwr),
    .xbe     (xbe),
    .xaddr   (xaddr),
    .xatai   (xatai),
    .xdack   (xdack),
    .busy    (busy),
    .cpu_res (cpu_res),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // darkram X-port responder: logs each acknowledged write, flags instability
  initial begin
    xdack = 1'b0;
    in_req = 1'b0; acked = 1'b0; done_prev = 1'b0; wait_n = 0;
    forever begin
      @(negedge clk);
      xdack   = 1'b0;
      ack_now = 1'b0;
      if (xrd !== 1'b0) bus_bad++;
      if (reset === 1'b1 || xdreq !== 1'b1) begin
        in_req = 1'b0;
      end else if (acked) begin
        bus_bad++;
      end else begin
        if (!in_req) begin
          in_req = 1'b1;
          cap_a  = xaddr;
          cap_d  = xatai;
          wait_n = $urandom_range(dly_max, dly_min);
        end
        if (xaddr !== cap_a || xatai !== cap_d || xbe !== 4'hF || xwr !== 1'b1) bus_bad++;
        if (!no_ack) begin
          if (wait_n == 0) begin
            xdack   = 1'b1;
            ack_now = 1'b1;
            in_req  = 1'b0;
            wr_a.push_back(cap_a);
            wr_d.push_back(cap_d);
          end else begin
            wait_n--;
          end
        end
      end
      acked = ack_now;
      if (xdreq === 1'b0 && (xbe !== 4'h0 || xwr !== 1'b0)) bus_bad++;
      if (cpu_res !== busy) bus_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_prev) done_long++;
        if (cpu_res !== 1'b1) bus_bad++;
      end
      done_prev = (done === 1'b1);
    end
  end

  function automatic logic [31:0] log_a(input int k);
    if (k < wr_a.size()) return wr_a[k];
    return 'x;
  endfunction

  function automatic logic [31:0] log_d(input int k);
    if (k < wr_d.size()) return wr_d[k];
    return 'x;
  endfunction

  task automatic clear_logs(input int dmin, input int dmax);
    wr_a.delete();
    wr_d.delete();
    bus_bad   = 0;
    done_cnt  = 0;
    done_long = 0;
    dly_min   = dmin;
    dly_max   = dmax;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    if (bad_stop) repeat (DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    no_ack = 1'b0;
    clear_logs(0, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if ({xdreq, xwr, xrd, xbe} !== 7'h0) begin n_bad++; $display("FAIL reset_bus: got %b want 0", {xdreq, xwr, xrd, xbe}); end
    n_cmp++; if (xaddr !== 32'h0) begin n_bad++; $display("FAIL reset_xaddr: got %h want 0", xaddr); end
    n_cmp++; if (xatai !== 32'h0) begin n_bad++; $display("FAIL reset_xatai: got %h want 0", xatai); end
    n_cmp++; if ({busy, cpu_res, done, err} !== 4'h0) begin n_bad++; $display("FAIL reset_status: got %b want 0000", {busy, cpu_res, done, err}); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    clear_logs(0, 0);
    send_byte(8'hA5, 1'b0);
    n_cmp++; if ({busy, cpu_res} !== 2'b11) begin n_bad++; $display("FAIL basic_busy_after_sync: got %b want 11", {busy, cpu_res}); end
    send_word(32'h0000_0100);
    send_word(32'd2);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    wait_idle(200);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got %b want 0", busy); end
    n_cmp++; if (wr_a.size() !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", wr_a.size()); end
    n_cmp++; if (log_a(0) !== 32'h100) begin n_bad++; $display("FAIL basic_addr0: got %h want 00000100", log_a(0)); end
    n_cmp++; if (log_d(0) !== 32'h1234_5678) begin n_bad++; $display("FAIL basic_data0: got %h want 12345678", log_d(0)); end
    n_cmp++; if (log_a(1) !== 32'h104) begin n_bad++; $display("FAIL basic_addr1: got %h want 00000104", log_a(1)); end
    n_cmp++; if (log_d(1) !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL basic_data1: got %h want deadbeef", log_d(1)); end
    n_cmp++; if (done_cnt !== 1 || done_long !== 0) begin n_bad++; $display("FAIL basic_done: got %0d pulses (%0d long) want 1 (0)", done_cnt, done_long); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
    n_cmp++; if (bus_bad !== 0) begin n_bad++; $display("FAIL basic_bus: got %0d violations want 0", bus_bad); end
  endtask

  task automatic test_random_ack;
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h0102_0304; exp_d[1] = 32'hCAFE_F00D; exp_d[2] = 32'h5A5A_A5A5;
    clear_logs(0, 20);
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0200);
    send_word(32'd3);
    for (int k = 0; k < 3; k++) send_word(exp_d[k]);
    wait_idle(200);
    n_cmp++; if (wr_a.size() !== 3) begin n_bad++; $display("FAIL rnd_nwrites: got %0d want 3", wr_a.size()); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (log_a(k) !== 32'h200 + 32'(4 * k)) begin n_bad++; $display("FAIL rnd_addr%0d: got %h want %h", k, log_a(k), 32'h200 + 32'(4 * k)); end
      n_cmp++; if (log_d(k) !== exp_d[k]) begin n_bad++; $display("FAIL rnd_data%0d: got %h want %h", k, log_d(k), exp_d[k]); end
    end
    n_cmp++; if (bus_bad !== 0) begin n_bad++; $display("FAIL rnd_bus_stable: got %0d violations want 0", bus_bad); end
    n_cmp++; if (done_cnt !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL rnd_done_err: got done=%0d err=%b want 1 0", done_cnt, err); end
  endtask

  task automatic test_hold;
    clear_logs(200, 200);
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0080);
    send_word(32'd2);
    send_word(32'h0BAD_F00D);
    send_word(32'h7654_3210);
    wait_idle(500);
    n_cmp++; if (wr_a.size() !== 2) begin n_bad++; $display("FAIL hold_nwrites: got %0d want 2", wr_a.size()); end
    n_cmp++; if (log_a(1) !== 32'h84 || log_d(1) !== 32'h7654_3210) begin n_bad++; $display("FAIL hold_word1: got %h@%h want 76543210@00000084", log_d(1), log_a(1)); end
    n_cmp++; if (done_cnt !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL hold_done_err: got done=%0d err=%b want 1 0", done_cnt, err); end
  endtask

  task automatic test_overrun;
    clear_logs(350, 350);
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0090);
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    wait_idle(500);
    n_cmp++; if (wr_a.size() !== 1 || log_d(0) !== 32'h1122_3344) begin n_bad++; $display("FAIL ovr_writes: got %0d writes first %h want 1 11223344", wr_a.size(), log_d(0)); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovr_err: got %b want 1", err); end
    n_cmp++; if (done_cnt !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL ovr_done_busy: got done=%0d busy=%b want 0 0", done_cnt, busy); end
    n_cmp++; if (bus_bad !== 0) begin n_bad++; $display("FAIL ovr_bus: got %0d violations want 0", bus_bad); end
  endtask

  task automatic test_wrap;
    clear_logs(0, 5);
    send_byte(8'hA5, 1'b0);
    send_word(32'hFFFF_FFFC);
    send_word(32'd2);
    send_word(32'hAAAA_5555);
    send_word(32'h0F0F_0F0F);
    wait_idle(200);
    n_cmp++; if (log_a(0) !== 32'hFFFF_FFFC || log_d(0) !== 32'hAAAA_5555) begin n_bad++; $display("FAIL wrap_word0: got %h@%h want aaaa5555@fffffffc", log_d(0), log_a(0)); end
    n_cmp++; if (log_a(1) !== 32'h0 || log_d(1) !== 32'h0F0F_0F0F) begin n_bad++; $display("FAIL wrap_word1: got %h@%h want 0f0f0f0f@00000000", log_d(1), log_a(1)); end
    n_cmp++; if (err !== 1'b0 || done_cnt !== 1) begin n_bad++; $display("FAIL wrap_done_err: got done=%0d err=%b want 1 0", done_cnt, err); end
  endtask

  task automatic test_count_zero;
    clear_logs(0, 0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cz_garbage_busy: got %b want 0", busy); end
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0040);
    send_word(32'd0);
    wait_idle(100);
    n_cmp++; if (wr_a.size() !== 0) begin n_bad++; $display("FAIL cz_nwrites: got %0d want 0", wr_a.size()); end
    n_cmp++; if (done_cnt !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL cz_done_err: got done=%0d err=%b want 1 0", done_cnt, err); end
  endtask

  task automatic test_bad_stop;
    clear_logs(0, 0);
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0300);
    send_word(32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL badstop_abort: got err=%b busy=%b want 1 0", err, busy); end
    n_cmp++; if (done_cnt !== 0 || wr_a.size() !== 0) begin n_bad++; $display("FAIL badstop_nowrite: got done=%0d writes=%0d want 0 0", done_cnt, wr_a.size()); end
    send_byte(8'hA5, 1'b0);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL badstop_sync_clears: got err=%b busy=%b want 0 1", err, busy); end
    repeat (450) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badstop_hdr_timeout: got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout;
    clear_logs(0, 0);
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0400);
    send_word(32'd1);
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    repeat (300) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL tmo_before: got busy=%b err=%b want 1 0", busy, err); end
    repeat (150) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL tmo_after: got busy=%b err=%b want 0 1", busy, err); end
    n_cmp++; if (wr_a.size() !== 0 || done_cnt !== 0) begin n_bad++; $display("FAIL tmo_nowrite: got writes=%0d done=%0d want 0 0", wr_a.size(), done_cnt); end
  endtask

  task automatic test_reset_mid;
    clear_logs(0, 0);
    no_ack = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_word(32'h0000_0500);
    send_word(32'd1);
    send_word(32'h1357_2468);
    for (int i = 0; i < 100 && xdreq !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (xdreq !== 1'b1) begin n_bad++; $display("FAIL rmid_req: got %b want 1", xdreq); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (xdreq !== 1'b0 || xbe !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_async_drop: got xdreq=%b xbe=%h busy=%b want 0 0 0", xdreq, xbe, busy); end
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    no_ack = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++; if (xdreq !== 1'b0 || wr_a.size() !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet: got xdreq=%b writes=%0d busy=%b want 0 0 0", xdreq, wr_a.size(), busy); end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset;
    test_basic;
    test_random_ack;
    test_hold;
    test_overrun;
    test_wrap;
    test_count_zero;
    test_bad_stop;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
